posit_field_extract: RTL

- Pipeline stage directly downstream of the regime/seed decode stage.
- Consumes the raw posit word, the signed regime seed and the regime-stripped shifted word.
- Produces the unpacked fields for the arithmetic datapath:
  - sign
  - combined scale (seed·2^ES + exponent)
  - fraction with hidden bit
  - zero/NaR flags
- Registered output behind a 2-entry skid buffer with valid/ready on both sides; full throughput.

---
 rtl/posit_pkg.sv | 36 +++
 rtl/posit_skid_buffer.sv | 88 ++++++++
 rtl/posit_field_extract.sv | 71 +++++++
 3 files changed

// File: rtl/posit_pkg.sv
// Shared posit types and constants for the decode pipeline.
// Field bundle layout is fixed by the package defaults.
package posit_pkg;

    localparam int POSIT_BITS = 32;
    localparam int POSIT_ES   = 2;

    function automatic int frac_width(input int bits, input int es);
        return bits - es - 3;
    endfunction

    localparam int POSIT_FRAC_W = frac_width(POSIT_BITS, POSIT_ES);

    function automatic logic [POSIT_BITS-1:0] zero_pattern();
        return '0;
    endfunction

    function automatic logic [POSIT_BITS-1:0] nar_pattern();
        return {1'b1, {(POSIT_BITS-1){1'b0}}};
    endfunction

    typedef struct packed {
        logic                         sign;
        logic signed [POSIT_BITS-1:0] scale;
        logic [POSIT_FRAC_W:0]        frac;
        logic                         zero;
        logic                         nar;
    } posit_fields_t;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_t;

endpackage

// File: rtl/posit_skid_buffer.sv
// Two-entry valid/ready register slice, full throughput.
// Main entry drives the outputs; skid absorbs one word of backpressure.
module posit_skid_buffer
    import posit_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state_q;
    skid_state_t  state_n;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         ready_q;
    logic         xfer_in;
    logic         xfer_out;
    logic         load_main;
    logic         load_skid;
    logic         pop_skid;

    assign xfer_in  = in_valid & ready_q;
    assign xfer_out = (state_q != SKID_EMPTY) & out_ready;

    always_comb begin
        state_n   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        unique case (state_q)
            SKID_EMPTY: begin
                if (xfer_in) begin
                    state_n   = SKID_ONE;
                    load_main = 1'b1;
                end
            end
            SKID_ONE: begin
                if (xfer_in && xfer_out) begin
                    load_main = 1'b1;
                end else if (xfer_in) begin
                    state_n   = SKID_FULL;
                    load_skid = 1'b1;
                end else if (xfer_out) begin
                    state_n = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (xfer_out) begin
                    state_n  = SKID_ONE;
                    pop_skid = 1'b1;
                end
            end
            default: state_n = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SKID_EMPTY;
            ready_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_n;
            ready_q <= (state_n != SKID_FULL);
            if (load_main) begin
                main_q <= in_data;
            end else if (pop_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q != SKID_EMPTY);
    assign out_data  = main_q;

endmodule

// File: rtl/posit_field_extract.sv
// Unpacks sign, scale, hidden-bit fraction and special flags
// from the regime-stripped posit word, behind a skid buffer.
module posit_field_extract
    import posit_pkg::*;
#(
    parameter  int BITS   = POSIT_BITS,
    parameter  int ES     = POSIT_ES,
    localparam int FRAC_W = frac_width(BITS, ES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BITS-1:0]        in_raw,
    input  logic signed [BITS-1:0] in_seed,
    input  logic [BITS-1:0]        in_shifted,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sign,
    output logic signed [BITS-1:0] out_scale,
    output logic [FRAC_W:0]        out_frac,
    output logic                   out_zero,
    output logic                   out_nar
);

    logic [ES-1:0]   exp_c;
    logic [BITS-1:0] exp_ext;
    logic            is_zero;
    logic            is_nar;
    posit_fields_t   fields_c;
    posit_fields_t   fields_q;

    assign exp_c   = in_shifted[BITS-1 -: ES];
    assign exp_ext = {{(BITS-ES){1'b0}}, exp_c};
    assign is_zero = (in_raw == zero_pattern());
    assign is_nar  = (in_raw == nar_pattern());

    // Specials ignore seed/shifted entirely.
    always_comb begin
        fields_c = '0;
        unique case (1'b1)
            is_zero: fields_c.zero = 1'b1;
            is_nar:  fields_c.nar  = 1'b1;
            default: begin
                fields_c.sign  = in_raw[BITS-1];
                fields_c.scale = (in_seed <<< ES) + exp_ext;
                fields_c.frac  = {1'b1, in_shifted[BITS-ES-1 -: FRAC_W]};
            end
        endcase
    end

    posit_skid_buffer #(
        .W($bits(posit_fields_t))
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (fields_c),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (fields_q)
    );

    assign out_sign  = fields_q.sign;
    assign out_scale = fields_q.scale;
    assign out_frac  = fields_q.frac;
    assign out_zero  = fields_q.zero;
    assign out_nar   = fields_q.nar;

endmodule
